// File: rtl/alu_pkg.sv
// Shared encodings for the ALU command controller: op codes, FSM states and
// the bit positions of the five ALU flags inside a packed response flag word.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FLG_Z  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_S  = 2;
  localparam int FLG_P  = 3;
  localparam int FLG_V  = 4;
  localparam int FLG_NB = 5;

  function automatic logic [FLG_NB-1:0] pack_flags(
    input logic zero,
    input logic carry,
    input logic sign,
    input logic parity,
    input logic overflow
  );
    logic [FLG_NB-1:0] f;
    f        = '0;
    f[FLG_Z] = zero;
    f[FLG_C] = carry;
    f[FLG_S] = sign;
    f[FLG_P] = parity;
    f[FLG_V] = overflow;
    return f;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Single-issue command controller for the combinational ALU: latches operands,
// captures the ALU result/flags one cycle later and holds them until consumed.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_src_acc,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_select,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_sign,
  input  logic          alu_parity,
  input  logic          alu_overflow,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic [4:0]    rsp_flags,
  output logic          rsp_err,
  output logic [W-1:0]  acc,
  output logic [CW-1:0] op_cnt
);

  state_t          r_state;
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic [W-1:0]    r_alu_a;
  logic [W-1:0]    r_alu_b;
  logic [1:0]      r_alu_select;
  logic [W-1:0]    r_rsp_data;
  logic [4:0]      r_rsp_flags;
  logic            r_rsp_err;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_op_cnt;

  logic            w_cmd_fire;
  logic            w_div_zero;
  logic [W-1:0]    w_opnd_a;
  logic [4:0]      w_alu_flags;

  assign w_cmd_fire  = cmd_valid && r_cmd_ready;
  assign w_div_zero  = (cmd_op == OP_DIV) && (cmd_b == '0);
  assign w_opnd_a    = cmd_src_acc ? r_acc : cmd_a;
  assign w_alu_flags = pack_flags(alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow);

  // cmd_ready/rsp_valid are registered alongside the state so they stay a
  // pure function of the state and never see cmd_valid combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_select <= '0;
      r_rsp_data   <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_acc        <= '0;
      r_op_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_alu_a     <= w_opnd_a;
            r_alu_b     <= cmd_b;
            r_cmd_ready <= 1'b0;
            if (w_div_zero) begin
              // Never show a divide-by-zero to the ALU; answer immediately.
              r_alu_select <= OP_ADD;
              r_rsp_data   <= '0;
              r_rsp_flags  <= '0;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_alu_select <= cmd_op;
              r_state      <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_flags <= w_alu_flags;
          r_rsp_err   <= 1'b0;
          r_acc       <= alu_out;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_op_cnt    <= r_op_cnt + CW'(1);
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_select = r_alu_select;
  assign rsp_data   = r_rsp_data;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;
  assign acc        = r_acc;
  assign op_cnt     = r_op_cnt;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a small behavioural 4-bit ALU beside it.
module tb_alu_ctrl;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_src_acc;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [W-1:0]  alu_a, alu_b;
  logic [1:0]    alu_select;
  logic [W-1:0]  alu_out;
  logic          alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [4:0]    rsp_flags;
  logic          rsp_err;
  logic [W-1:0]  acc;
  logic [CW-1:0] op_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_acc(cmd_src_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_sign(alu_sign), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc), .op_cnt(op_cnt)
  );

  // Behavioural ALU: 5-bit raw result, sign-compare overflow for every op.
  logic [4:0] alu_res;
  logic [7:0] alu_prod;
  always_comb begin
    alu_prod = {4'b0, alu_a} * {4'b0, alu_b};
    alu_res  = '0;
    case (alu_select)
      2'd0: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      2'd2: alu_res = alu_prod[4:0];
      default: alu_res = (alu_b == '0) ? 5'd0 : {1'b0, alu_a / alu_b};
    endcase
    alu_out      = alu_res[3:0];
    alu_zero     = (alu_res[3:0] == 4'd0);
    alu_carry    = alu_res[4];
    alu_sign     = alu_res[3];
    alu_parity   = ~^alu_res[3:0];
    alu_overflow = (alu_a[3] == alu_b[3]) && (alu_res[3] != alu_a[3]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a command at edge N, check EXEC at N, response at N+1.
  task automatic exec_op(input string tag, input logic [1:0] op, input logic src,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp_a,
                         input logic [3:0] exp_data, input logic [4:0] exp_flags);
    cmd_valid = 1'b1; cmd_op = op; cmd_src_acc = src; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0;
    check({tag, "_alu_a"}, 32'(alu_a), 32'(exp_a));
    check({tag, "_alu_b"}, 32'(alu_b), 32'(b));
    check({tag, "_alu_sel"}, 32'(alu_select), 32'(op));
    check({tag, "_exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_exec_cmd_ready"}, 32'(cmd_ready), 32'd0);
    tick();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'(exp_flags));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_acc"}, 32'(acc), 32'(exp_data));
  endtask

  task automatic finish_op(input string tag, input logic [CW-1:0] exp_cnt);
    tick();
    check({tag, "_done_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_op_cnt"}, 32'(op_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src_acc = 1'b0;
    cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_select), 32'd0);

    // flags word is {V,P,S,C,Z}
    exec_op("add", 2'd0, 1'b0, 4'd7, 4'd9, 4'd7, 4'h0, 5'b01011);
    finish_op("add", 3'd1);
    exec_op("sub", 2'd1, 1'b0, 4'd3, 4'd5, 4'd3, 4'hE, 5'b10110);
    finish_op("sub", 3'd2);
    exec_op("mul", 2'd2, 1'b0, 4'd5, 4'd4, 4'd5, 4'h4, 5'b00010);
    finish_op("mul", 3'd3);
    exec_op("chain", 2'd0, 1'b1, 4'hF, 4'd3, 4'd4, 4'h7, 5'b00000);
    finish_op("chain", 3'd4);

    // Divide by zero answers right after the accepting edge.
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_src_acc = 1'b0; cmd_a = 4'd9; cmd_b = 4'd0;
    tick();
    cmd_valid = 1'b0;
    check("div0_rsp_valid", 32'(rsp_valid), 32'd1);
    check("div0_rsp_err", 32'(rsp_err), 32'd1);
    check("div0_rsp_data", 32'(rsp_data), 32'd0);
    check("div0_rsp_flags", 32'(rsp_flags), 32'd0);
    check("div0_alu_sel", 32'(alu_select), 32'd0);
    check("div0_alu_a", 32'(alu_a), 32'd9);
    check("div0_acc", 32'(acc), 32'd7);
    check("div0_cmd_ready", 32'(cmd_ready), 32'd0);
    finish_op("div0", 3'd5);

    // Backpressure: SUB 9-1 = 8, flags S only; a competing command must be ignored.
    rsp_ready = 1'b0;
    exec_op("bp", 2'd1, 1'b0, 4'd9, 4'd1, 4'd9, 4'h8, 5'b00100);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 4'd2; cmd_b = 4'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_hold_data", 32'(rsp_data), 32'h8);
      check("bp_hold_flags", 32'(rsp_flags), 32'b00100);
      check("bp_hold_op_cnt", 32'(op_cnt), 32'd5);
      check("bp_hold_alu_a", 32'(alu_a), 32'd9);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    finish_op("bp", 3'd6);

    // Reset while in EXEC drops the command.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src_acc = 1'b0; cmd_a = 4'd1; cmd_b = 4'd1;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rexec_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rexec_acc", 32'(acc), 32'd0);
    check("rexec_op_cnt", 32'(op_cnt), 32'd0);
    check("rexec_alu_a", 32'(alu_a), 32'd0);
    tick();
    check("rexec_no_rsp", 32'(rsp_valid), 32'd0);

    // op_cnt wraps modulo 2^CW.
    for (int i = 1; i <= 8; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 4'd5; cmd_b = 4'd0;
      tick();
      cmd_valid = 1'b0;
      tick();
      if (i == 7) check("wrap_cnt7", 32'(op_cnt), 32'd7);
      if (i == 8) check("wrap_cnt0", 32'(op_cnt), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
